// File: rtl/rv_rr_arbiter.sv
// rv_rr_arbiter
//   Request arbiter for warp/thread selection and shared-port muxing.
//   Picks one of NUM_REQS requesters per cycle with a combinational
//   request-to-grant path. MODE 0 is fixed priority (index 0 highest),
//   MODE 1 is round-robin. With LOCK_ENABLE = 1 a grant that the consumer
//   does not accept is held on the same requester until it fires or the
//   requester drops its request.
//
// Ports
//   clk           rising-edge clock for all state
//   reset         synchronous, active-high
//   requests      request vector, bit i = requester i
//   enable        consumer accepts the current grant (fire = grant_valid && enable)
//   grant_index   binary index of the granted requester (0 when nothing granted)
//   grant_onehot  one-hot grant, all-zero when grant_valid = 0
//   grant_valid   at least one request is granted
module rv_rr_arbiter #(
  parameter int NUM_REQS     = 8,
  parameter int LOCK_ENABLE  = 0,
  parameter int MODE         = 1,
  parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQS-1:0]     requests,
  input  logic                    enable,
  output logic [LOG_NUM_REQS-1:0] grant_index,
  output logic [NUM_REQS-1:0]     grant_onehot,
  output logic                    grant_valid
);

  generate
    if (NUM_REQS == 1) begin : g_single
      // Single requester: pure pass-through, no state.
      logic unused_inputs;
      assign unused_inputs = ^{clk, reset, enable};

      assign grant_index  = '0;
      assign grant_onehot = requests;
      assign grant_valid  = requests[0];
    end else begin : g_multi
      logic [LOG_NUM_REQS-1:0] prio_ptr_q, prio_ptr_d;
      logic [LOG_NUM_REQS-1:0] lock_index_q, lock_index_d;
      logic                    lock_valid_q, lock_valid_d;

      logic [LOG_NUM_REQS-1:0] prio_ptr_eff;
      logic                    lock_valid_eff;
      logic                    lock_hit;
      logic [LOG_NUM_REQS-1:0] fp_idx;
      logic [LOG_NUM_REQS-1:0] rr_idx;
      logic                    rr_found;
      logic [LOG_NUM_REQS:0]   rr_sum;
      logic [LOG_NUM_REQS-1:0] rr_pos;
      logic                    fire;

      // While reset is high the outputs already behave as if state were
      // cleared, so the grant during reset follows index-0-first order.
      assign prio_ptr_eff   = reset ? '0 : prio_ptr_q;
      assign lock_valid_eff = reset ? 1'b0 : lock_valid_q;

      // A lock only applies while its requester is still asking.
      assign lock_hit = lock_valid_eff && requests[lock_index_q];

      always_comb begin
        fp_idx = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
          if (requests[i]) fp_idx = LOG_NUM_REQS'(i);
        end
      end

      // Rotating scan from prio_ptr; the wrap is an explicit subtract so
      // non-power-of-two NUM_REQS works. ptr < N and i < N keeps the sum
      // below 2N, so a single subtract is enough.
      always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        rr_sum   = '0;
        rr_pos   = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
          rr_sum = {1'b0, prio_ptr_eff} + (LOG_NUM_REQS+1)'(i);
          if (rr_sum >= (LOG_NUM_REQS+1)'(NUM_REQS)) begin
            rr_sum = rr_sum - (LOG_NUM_REQS+1)'(NUM_REQS);
          end
          rr_pos = rr_sum[LOG_NUM_REQS-1:0];
          if (!rr_found && requests[rr_pos]) begin
            rr_found = 1'b1;
            rr_idx   = rr_pos;
          end
        end
      end

      always_comb begin
        grant_valid = |requests;
        grant_index = '0;
        if (grant_valid) begin
          if (lock_hit)         grant_index = lock_index_q;
          else if (MODE == 1)   grant_index = rr_idx;
          else                  grant_index = fp_idx;
        end
        grant_onehot = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
          grant_onehot[i] = grant_valid && (grant_index == LOG_NUM_REQS'(i));
        end
      end

      assign fire = grant_valid && enable;

      always_comb begin
        prio_ptr_d = prio_ptr_q;
        if (MODE == 1 && fire) begin
          prio_ptr_d = (grant_index == LOG_NUM_REQS'(NUM_REQS - 1)) ?
                       '0 : grant_index + LOG_NUM_REQS'(1);
        end

        // Lock is cleared by default: a fire, a dropped requester or an
        // idle cycle all release it unless the hold condition re-arms it.
        lock_valid_d = 1'b0;
        lock_index_d = lock_index_q;
        if (LOCK_ENABLE != 0 && grant_valid && !enable) begin
          lock_valid_d = 1'b1;
          lock_index_d = grant_index;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          prio_ptr_q   <= '0;
          lock_valid_q <= 1'b0;
          lock_index_q <= '0;
        end else begin
          prio_ptr_q   <= prio_ptr_d;
          lock_valid_q <= lock_valid_d;
          lock_index_q <= lock_index_d;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_rv_rr_arbiter.sv
module tb_rv_rr_arbiter;

  logic clk;
  logic reset;

  // round-robin, no lock
  logic [3:0] rr_req;  logic rr_en;  logic [1:0] rr_idx;  logic [3:0] rr_oh;  logic rr_vld;
  // fixed priority, no lock
  logic [3:0] fp_req;  logic fp_en;  logic [1:0] fp_idx;  logic [3:0] fp_oh;  logic fp_vld;
  // round-robin with lock
  logic [3:0] lk_req;  logic lk_en;  logic [1:0] lk_idx;  logic [3:0] lk_oh;  logic lk_vld;
  // three requesters, round-robin
  logic [2:0] n3_req;  logic n3_en;  logic [1:0] n3_idx;  logic [2:0] n3_oh;  logic n3_vld;
  // single requester
  logic [0:0] one_req; logic one_en; logic [0:0] one_idx; logic [0:0] one_oh; logic one_vld;

  int checks = 0;
  int errors = 0;

  rv_rr_arbiter #(.NUM_REQS(4), .LOCK_ENABLE(0), .MODE(1)) u_rr (
    .clk(clk), .reset(reset), .requests(rr_req), .enable(rr_en),
    .grant_index(rr_idx), .grant_onehot(rr_oh), .grant_valid(rr_vld));

  rv_rr_arbiter #(.NUM_REQS(4), .LOCK_ENABLE(0), .MODE(0)) u_fp (
    .clk(clk), .reset(reset), .requests(fp_req), .enable(fp_en),
    .grant_index(fp_idx), .grant_onehot(fp_oh), .grant_valid(fp_vld));

  rv_rr_arbiter #(.NUM_REQS(4), .LOCK_ENABLE(1), .MODE(1)) u_lk (
    .clk(clk), .reset(reset), .requests(lk_req), .enable(lk_en),
    .grant_index(lk_idx), .grant_onehot(lk_oh), .grant_valid(lk_vld));

  rv_rr_arbiter #(.NUM_REQS(3), .LOCK_ENABLE(0), .MODE(1)) u_n3 (
    .clk(clk), .reset(reset), .requests(n3_req), .enable(n3_en),
    .grant_index(n3_idx), .grant_onehot(n3_oh), .grant_valid(n3_vld));

  rv_rr_arbiter #(.NUM_REQS(1), .LOCK_ENABLE(0), .MODE(1)) u_one (
    .clk(clk), .reset(reset), .requests(one_req), .enable(one_en),
    .grant_index(one_idx), .grant_onehot(one_oh), .grant_valid(one_vld));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rr_req; logic rr_en; logic [1:0] rr_idx; logic [3:0] rr_oh;
    logic [3:0] fp_req; logic fp_en; logic [1:0] fp_idx; logic [3:0] fp_oh;
    logic [3:0] lk_req; logic lk_en; logic [1:0] lk_idx; logic [3:0] lk_oh;
  } vec_t;

  vec_t vec [12];

  task automatic check(input string name, input int step,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  // Walk a 4-requester instance's outputs against expected index/onehot.
  task automatic check4(input string name, input int step,
                        input logic [1:0] idx, input logic [3:0] oh, input logic vld,
                        input logic [1:0] e_idx, input logic [3:0] e_oh);
    check({name, "_idx"}, step, 32'(idx), 32'(e_idx));
    check({name, "_oh"},  step, 32'(oh),  32'(e_oh));
    check({name, "_vld"}, step, 32'(vld), 32'(e_oh != 4'b0000));
  endtask

  initial begin
    logic [2:0] n3_reqs [6];
    logic [1:0] n3_exp  [6];

    //        rr: req    en    idx   oh       fp: req    en    idx   oh       lk: req    en    idx   oh
    vec[0]  = '{4'b1111, 1'b1, 2'd0, 4'b0001, 4'b1110, 1'b1, 2'd1, 4'b0010, 4'b0110, 1'b0, 2'd1, 4'b0010};
    vec[1]  = '{4'b1111, 1'b1, 2'd1, 4'b0010, 4'b1110, 1'b1, 2'd1, 4'b0010, 4'b0110, 1'b0, 2'd1, 4'b0010};
    vec[2]  = '{4'b1111, 1'b1, 2'd2, 4'b0100, 4'b1110, 1'b1, 2'd1, 4'b0010, 4'b0111, 1'b0, 2'd1, 4'b0010};
    vec[3]  = '{4'b1111, 1'b1, 2'd3, 4'b1000, 4'b1110, 1'b1, 2'd1, 4'b0010, 4'b0111, 1'b1, 2'd1, 4'b0010};
    vec[4]  = '{4'b1111, 1'b1, 2'd0, 4'b0001, 4'b0000, 1'b1, 2'd0, 4'b0000, 4'b0111, 1'b1, 2'd2, 4'b0100};
    vec[5]  = '{4'b1001, 1'b1, 2'd3, 4'b1000, 4'b1000, 1'b1, 2'd3, 4'b1000, 4'b0100, 1'b0, 2'd2, 4'b0100};
    vec[6]  = '{4'b1001, 1'b1, 2'd0, 4'b0001, 4'b1010, 1'b1, 2'd1, 4'b0010, 4'b1101, 1'b0, 2'd2, 4'b0100};
    vec[7]  = '{4'b1001, 1'b1, 2'd3, 4'b1000, 4'b0101, 1'b0, 2'd0, 4'b0001, 4'b1001, 1'b1, 2'd3, 4'b1000};
    vec[8]  = '{4'b1001, 1'b1, 2'd0, 4'b0001, 4'b1111, 1'b1, 2'd0, 4'b0001, 4'b1111, 1'b0, 2'd0, 4'b0001};
    vec[9]  = '{4'b0000, 1'b1, 2'd0, 4'b0000, 4'b1111, 1'b1, 2'd0, 4'b0001, 4'b1110, 1'b1, 2'd1, 4'b0010};
    vec[10] = '{4'b0100, 1'b0, 2'd2, 4'b0100, 4'b1111, 1'b1, 2'd0, 4'b0001, 4'b1111, 1'b1, 2'd2, 4'b0100};
    vec[11] = '{4'b0110, 1'b0, 2'd1, 4'b0010, 4'b1111, 1'b1, 2'd0, 4'b0001, 4'b1111, 1'b1, 2'd3, 4'b1000};

    n3_reqs = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b101, 3'b101};
    n3_exp  = '{2'd0,   2'd1,   2'd2,   2'd0,   2'd2,   2'd0};

    reset = 1'b1;
    rr_req = '0; rr_en = 1'b0; fp_req = '0; fp_en = 1'b0;
    lk_req = '0; lk_en = 1'b0; n3_req = '0; n3_en = 1'b0;
    one_req = '0; one_en = 1'b0;

    // Reset state with no requests
    repeat (2) @(negedge clk);
    #1;
    check4("rst_rr", 0, rr_idx, rr_oh, rr_vld, 2'd0, 4'b0000);
    check4("rst_fp", 0, fp_idx, fp_oh, fp_vld, 2'd0, 4'b0000);
    check4("rst_lk", 0, lk_idx, lk_oh, lk_vld, 2'd0, 4'b0000);

    @(negedge clk);
    reset = 1'b0;

    for (int s = 0; s < 12; s++) begin
      @(negedge clk);
      rr_req = vec[s].rr_req; rr_en = vec[s].rr_en;
      fp_req = vec[s].fp_req; fp_en = vec[s].fp_en;
      lk_req = vec[s].lk_req; lk_en = vec[s].lk_en;
      #1;
      check4("rr", s, rr_idx, rr_oh, rr_vld, vec[s].rr_idx, vec[s].rr_oh);
      check4("fp", s, fp_idx, fp_oh, fp_vld, vec[s].fp_idx, vec[s].fp_oh);
      check4("lk", s, lk_idx, lk_oh, lk_vld, vec[s].lk_idx, vec[s].lk_oh);
    end

    // Build up ptr = 2 and a lock on index 2, then reset mid-lock.
    @(negedge clk);
    lk_req = 4'b0010; lk_en = 1'b1;
    #1;
    check4("lkrst_a", 0, lk_idx, lk_oh, lk_vld, 2'd1, 4'b0010);
    @(negedge clk);
    lk_req = 4'b1111; lk_en = 1'b0;
    #1;
    check4("lkrst_b", 1, lk_idx, lk_oh, lk_vld, 2'd2, 4'b0100);
    @(negedge clk);
    reset = 1'b1; lk_req = 4'b1111; lk_en = 1'b1;   // fire during reset must not move ptr
    #1;
    check4("lkrst_during", 2, lk_idx, lk_oh, lk_vld, 2'd0, 4'b0001);
    @(negedge clk);
    reset = 1'b0; lk_req = 4'b1111; lk_en = 1'b0;
    #1;
    check4("lkrst_after", 3, lk_idx, lk_oh, lk_vld, 2'd0, 4'b0001);
    @(negedge clk);
    lk_req = 4'b0000; lk_en = 1'b0;
    #1;
    check4("lkrst_idle", 4, lk_idx, lk_oh, lk_vld, 2'd0, 4'b0000);

    // Non-power-of-two wrap
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      n3_req = n3_reqs[s]; n3_en = 1'b1;
      #1;
      check("n3_idx", s, 32'(n3_idx), 32'(n3_exp[s]));
      check("n3_oh",  s, 32'(n3_oh),  32'(3'b001 << n3_exp[s]));
      check("n3_vld", s, 32'(n3_vld), 32'd1);
    end

    // Single requester pass-through
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      one_req = 1'(s & 1); one_en = 1'(s >> 1);
      #1;
      check("one_idx", s, 32'(one_idx), 32'd0);
      check("one_oh",  s, 32'(one_oh),  32'(s & 1));
      check("one_vld", s, 32'(one_vld), 32'(s & 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
